ch_in_buff: RTL and testbench
=============================

# ch_in_buff

Parametrised multi-channel input sample buffer for the ultrasound receive path. It accepts one frame per write, where a frame is one sample from each of NUM_CH receive channels captured together. Frames are stored in a circular buffer of 2^ADDR_WIDTH entries and read out one channel at a time through a valid/ready handshake to the downstream beamforming logic. Compared with the single-channel free-running FIFO, it adds:
- multiple channels;
- back-pressure;
- full, empty and almost-full status;
- a sticky overflow flag.

## Interface
Parameters:
- DATA_WIDTH, 16, bits per channel sample
- ADDR_WIDTH, 3, log2 of frame depth; DEPTH = 2^ADDR_WIDTH frames
- NUM_CH, 4, channels per frame; must be ≥2
- AFULL_LEVEL, DEPTH-2, frame count at or above which almost_full is asserted

Ports (CH_W = clog2(NUM_CH)):
- clk  in  1  single clock; all logic is on the rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  a frame is presented on in_data
- in_data  in  NUM_CH*DATA_WIDTH  frame; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]
- in_ready  out  1  buffer can accept a frame (not full)
- out_valid  out  1  the current sample is valid (buffer not empty)
- out_ready  in  1  downstream accepts the current sample
- out_data  out  DATA_WIDTH  current sample
- out_ch  out  CH_W  channel index of out_data
- out_last  out  1  out_ch == NUM_CH-1 while out_valid
- fifo_count  out  ADDR_WIDTH+1  frames stored, range 0..DEPTH
- almost_full  out  1  fifo_count ≥ AFULL_LEVEL
- overflow  out  1  sticky flag: a frame was dropped
- clr_overflow  in  1  clears overflow

## Operation
- **Push.** A frame is written when in_valid && in_ready. It is stored at mem[wr_ptr], then wr_ptr increments modulo DEPTH and count increments.
- **Flags.** in_ready = (count != DEPTH). out_valid = (count != 0).
- **Read-out.** The buffer is first-word-fall-through. out_data = mem[rd_ptr][ch_idx] when out_valid, and 0 when empty.
- **Pop.** A sample is consumed when out_valid && out_ready.
  - If ch_idx < NUM_CH-1, ch_idx increments.
  - Otherwise (frame pop), ch_idx returns to 0, rd_ptr increments modulo DEPTH and count decrements.
- **Simultaneous push and frame pop.** count is unchanged and both pointers advance.
- **Full with simultaneous frame pop.** in_ready is low, so the push is refused that cycle; there is no combinational in_ready path from out_ready.
- **Drop.** in_valid && !in_ready drops the frame: storage is unchanged and overflow is set at the next edge.
- **Overflow clear.** clr_overflow clears overflow. If a drop and clr_overflow occur in the same cycle, the set wins.
- **Pointer wrap.** Pointers wrap silently. count alone distinguishes full from empty.
- **Reset.** Reset is synchronous and overrides all activity in that cycle. After reset:
  - wr_ptr = rd_ptr = ch_idx = 0 and count = 0;
  - overflow = 0, in_ready = 1, out_valid = 0, out_data = 0, out_ch = 0, out_last = 0, almost_full = 0.
  - Memory contents are not cleared.
  - If reset is asserted mid-frame, the partially read frame is discarded.

## Timing
- Push to out_valid: a frame written at edge N is visible on out_valid/out_data after edge N; there is 1 cycle of latency.
- Each frame needs NUM_CH accepted handshakes to drain. Sustained throughput is 1 frame per NUM_CH cycles with out_ready held high.
- out_data, out_ch and out_last are combinational from registered state. They hold stable while out_valid && !out_ready.
- in_ready, almost_full and overflow are registered or derived from registered count only.
- There are no combinational paths from in_valid or out_ready to any output.

## Structure
- Shared package or header: the CH_W computation (clog2 function) and the frame-width macro NUM_CH*DATA_WIDTH.
- One sub-module, ch_in_buff_ram: a simple dual-port memory of DEPTH × NUM_CH*DATA_WIDTH with a synchronous write and an asynchronous read.
- The top level holds the pointers, count, ch_idx, the flags and the channel read mux.

## Test plan
Use defaults (DATA_WIDTH=16, ADDR_WIDTH=3, NUM_CH=4) unless noted.
1. **Reset values.** Assert reset for 2 cycles → all outputs are at their reset values and fifo_count=0.
2. **Single frame.** Push frame {0x103,0x102,0x101,0x100} (ch3..ch0), out_ready=1 → out_data sequence is 0x100, 0x101, 0x102, 0x103 with out_ch 0..3 and out_last on the 4th sample; out_valid=0 afterwards.
3. **Fill and overflow.** Push 8 frames 0x2k0.. with out_ready=0 → fifo_count=8, in_ready=0, almost_full from count 6. A 9th push sets overflow=1 and fifo_count stays 8. Pulse clr_overflow → overflow=0.
4. **Wrap-around.** Push and drain 12 frames with out_ready toggling every other cycle → all 48 samples arrive in order, with no loss and no duplication across the pointer wrap.
5. **Simultaneous events.** Push during a frame pop at count=3 → count stays 3. At count=8, a frame pop plus in_valid → the push is refused, overflow=1, count=7.
6. **Reset mid-frame.** Assert reset after 2 of 4 samples are accepted → out_valid=0, ch_idx=0. The next pushed frame starts at ch0.

Source files
------------

// File: rtl/ch_in_buff_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ch_in_buff_pkg
//  Description : Shared helpers for the multi-channel input sample buffer:
//                channel-index width (clog2) and frame-width computation.
//  Revision    : 1.0 - initial release
// ============================================================================
package ch_in_buff_pkg;

    // Default geometry of the receive-path buffer.
    localparam int C_DEF_DATA_WIDTH = 16;
    localparam int C_DEF_ADDR_WIDTH = 3;
    localparam int C_DEF_NUM_CH     = 4;

    // Ceiling log2; returns 1 for n <= 2 so a channel index is never zero-width.
    function automatic int ch_clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        if (r < 1) r = 1;
        return r;
    endfunction

    // Width of one stored frame: one sample from every channel.
    function automatic int frame_w(input int num_ch, input int data_width);
        return num_ch * data_width;
    endfunction

endpackage : ch_in_buff_pkg
`default_nettype wire

// File: rtl/ch_in_buff_ram.sv
`default_nettype none
// ============================================================================
//  Module      : ch_in_buff_ram
//  Description : Simple dual-port frame store, DEPTH x WIDTH bits.
//                Synchronous write, asynchronous (combinational) read so the
//                buffer can present its head frame fall-through style.
//  Ports       : clk        - clock
//                wr_en_i    - write strobe
//                wr_addr_i  - write address
//                wr_data_i  - write data (one frame)
//                rd_addr_i  - read address
//                rd_data_o  - read data, combinational from rd_addr_i
//  Revision    : 1.0 - initial release
// ============================================================================
module ch_in_buff_ram #(
    parameter int ADDR_WIDTH = 3,
    parameter int WIDTH      = 64
) (
    input  logic                  clk,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]      wr_data_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [WIDTH-1:0]      rd_data_o
);

    localparam int C_DEPTH = 1 << ADDR_WIDTH;

    // Storage is deliberately not reset; emptiness is tracked by the count.
    logic [WIDTH-1:0] mem_q [C_DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule : ch_in_buff_ram
`default_nettype wire

// File: rtl/ch_in_buff.sv
`default_nettype none
// ============================================================================
//  Module      : ch_in_buff
//  Description : Multi-channel input sample buffer. Accepts one frame
//                (NUM_CH samples) per push into a circular store of
//                2^ADDR_WIDTH frames and streams it out one channel at a time
//                over a valid/ready handshake (first-word-fall-through).
//  Ports       : clk, reset            - clock, synchronous active-high reset
//                in_valid/in_data      - frame input, channel k at
//                                        [k*DATA_WIDTH +: DATA_WIDTH]
//                in_ready              - buffer not full
//                out_valid/out_ready   - sample output handshake
//                out_data/out_ch       - current sample and its channel
//                out_last              - last channel of the frame
//                fifo_count            - frames stored (0..DEPTH)
//                almost_full           - fifo_count >= AFULL_LEVEL
//                overflow/clr_overflow - sticky drop flag and its clear
//  Revision    : 1.0 - initial release
// ============================================================================
module ch_in_buff
    import ch_in_buff_pkg::*;
#(
    parameter int DATA_WIDTH  = C_DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH  = C_DEF_ADDR_WIDTH,
    parameter int NUM_CH      = C_DEF_NUM_CH,
    parameter int AFULL_LEVEL = (1 << ADDR_WIDTH) - 2,
    localparam int CH_W       = ch_clog2(NUM_CH)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
    output logic                         in_ready,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [CH_W-1:0]              out_ch,
    output logic                         out_last,
    output logic [ADDR_WIDTH:0]          fifo_count,
    output logic                         almost_full,
    output logic                         overflow,
    input  logic                         clr_overflow
);

    localparam int                  C_DEPTH   = 1 << ADDR_WIDTH;
    localparam int                  C_FRAME_W = frame_w(NUM_CH, DATA_WIDTH);
    localparam logic [ADDR_WIDTH:0] C_DEPTH_CNT = (ADDR_WIDTH+1)'(C_DEPTH);
    localparam logic [ADDR_WIDTH:0] C_AFULL     = (ADDR_WIDTH+1)'(AFULL_LEVEL);
    localparam logic [CH_W-1:0]     C_LAST_CH   = CH_W'(NUM_CH - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q,  count_d;
    logic [CH_W-1:0]       ch_idx_q, ch_idx_d;
    logic                  overflow_q, overflow_d;

    logic                  push;
    logic                  pop;
    logic                  frame_pop;
    logic                  drop;
    logic [C_FRAME_W-1:0]  rd_frame;
    logic [DATA_WIDTH-1:0] sample;

    // Status derives from registered count only, so in_ready never depends
    // combinationally on out_ready: a full buffer refuses a push even while
    // a frame is popping in the same cycle.
    assign in_ready  = (count_q != C_DEPTH_CNT);
    assign out_valid = (count_q != '0);

    assign push      = in_valid && in_ready;
    assign drop      = in_valid && !in_ready;
    assign pop       = out_valid && out_ready;
    assign frame_pop = pop && (ch_idx_q == C_LAST_CH);

    // ------------------------------------------------------------------
    // Frame store
    // ------------------------------------------------------------------
    ch_in_buff_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .WIDTH      (C_FRAME_W)
    ) u_ram (
        .clk        (clk),
        .wr_en_i    (push),
        .wr_addr_i  (wr_ptr_q),
        .wr_data_i  (in_data),
        .rd_addr_i  (rd_ptr_q),
        .rd_data_o  (rd_frame)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        ch_idx_d   = ch_idx_q;
        overflow_d = overflow_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;   // wraps modulo DEPTH
        end

        if (pop) begin
            if (frame_pop) begin
                ch_idx_d = '0;
                rd_ptr_d = rd_ptr_q + 1'b1;
            end else begin
                ch_idx_d = ch_idx_q + 1'b1;
            end
        end

        // Push and frame pop together leave the count unchanged.
        case ({push, frame_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // A drop in the same cycle as a clear keeps the flag set.
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ch_idx_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ch_idx_q   <= ch_idx_d;
            overflow_q <= overflow_d;
        end
    end

    // ------------------------------------------------------------------
    // Channel read mux (combinational from registered pointer/index)
    // ------------------------------------------------------------------
    always_comb begin
        sample = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ch_idx_q == CH_W'(k)) begin
                sample = rd_frame[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Memory is never cleared, so mask stale contents while empty.
    assign out_data    = out_valid ? sample : '0;
    assign out_ch      = ch_idx_q;
    assign out_last    = out_valid && (ch_idx_q == C_LAST_CH);
    assign fifo_count  = count_q;
    assign almost_full = (count_q >= C_AFULL);
    assign overflow    = overflow_q;

endmodule : ch_in_buff
`default_nettype wire

// File: tb/tb_ch_in_buff.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ch_in_buff
//  Description : Directed self-checking bench for ch_in_buff (default
//                geometry: 16-bit samples, 8 frames, 4 channels).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ch_in_buff;

    localparam int DW = 16;
    localparam int AW = 3;
    localparam int NC = 4;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic [NC*DW-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [DW-1:0]    out_data;
    logic [1:0]       out_ch;
    logic             out_last;
    logic [AW:0]      fifo_count;
    logic             almost_full;
    logic             overflow;
    logic             clr_overflow;

    int checks = 0;
    int errors = 0;

    ch_in_buff #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_CH     (NC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_ch       (out_ch),
        .out_last     (out_last),
        .fifo_count   (fifo_count),
        .almost_full  (almost_full),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Frame whose channel c sample is base + c.
    function automatic logic [NC*DW-1:0] mkframe(input logic [DW-1:0] base);
        logic [NC*DW-1:0] f;
        for (int c = 0; c < NC; c++) f[c*DW +: DW] = base + DW'(c);
        return f;
    endfunction

    task automatic push(input logic [DW-1:0] base);
        in_valid = 1'b1;
        in_data  = mkframe(base);
        tick();
        in_valid = 1'b0;
    endtask

    initial begin : stim
        int pushed;
        int rcv;
        int cyc;
        logic [DW-1:0] exp_s;

        reset = 1'b1; in_valid = 1'b0; in_data = '0;
        out_ready = 1'b0; clr_overflow = 1'b0;

        // ---------------- 1. reset values ----------------
        tick(); tick();
        chk("rst_in_ready",  32'(in_ready),    32'd1);
        chk("rst_out_valid", 32'(out_valid),   32'd0);
        chk("rst_out_data",  32'(out_data),    32'd0);
        chk("rst_out_ch",    32'(out_ch),      32'd0);
        chk("rst_out_last",  32'(out_last),    32'd0);
        chk("rst_count",     32'(fifo_count),  32'd0);
        chk("rst_afull",     32'(almost_full), 32'd0);
        chk("rst_overflow",  32'(overflow),    32'd0);
        reset = 1'b0;
        tick();

        // ---------------- 2. single frame ----------------
        push(16'h100);
        chk("sf_valid", 32'(out_valid),  32'd1);
        chk("sf_count", 32'(fifo_count), 32'd1);
        out_ready = 1'b1;
        for (int k = 0; k < NC; k++) begin
            chk("sf_data", 32'(out_data), 32'h100 + 32'(k));
            chk("sf_ch",   32'(out_ch),   32'(k));
            chk("sf_last", 32'(out_last), (k == NC-1) ? 32'd1 : 32'd0);
            tick();
        end
        out_ready = 1'b0;
        chk("sf_empty", 32'(out_valid), 32'd0);
        chk("sf_data0", 32'(out_data),  32'd0);

        // ---------------- 3. fill and overflow ----------------
        for (int k = 0; k < 8; k++) begin
            push(16'h200 + 16'(k*16));
            chk("fill_count", 32'(fifo_count), 32'(k+1));
            chk("fill_afull", 32'(almost_full), (k+1 >= 6) ? 32'd1 : 32'd0);
        end
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_ovf0",     32'(overflow), 32'd0);
        push(16'h2F0);
        chk("drop_ovf",   32'(overflow),   32'd1);
        chk("drop_count", 32'(fifo_count), 32'd8);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        chk("clr_ovf", 32'(overflow), 32'd0);
        out_ready = 1'b1;
        for (int s = 0; s < 8*NC; s++) begin
            chk("fill_drain", 32'(out_data), 32'h200 + 32'((s/NC)*16 + (s%NC)));
            tick();
        end
        out_ready = 1'b0;
        chk("fill_empty", 32'(fifo_count), 32'd0);

        // ---------------- 4. wrap-around, toggling ready ----------------
        pushed = 0; rcv = 0; cyc = 0;
        while (rcv < 12*NC && cyc < 400) begin
            in_valid  = (pushed < 12) && in_ready;
            in_data   = mkframe(16'h300 + 16'(pushed*16));
            out_ready = cyc[0];
            if (out_valid && out_ready) begin
                exp_s = 16'h300 + 16'((rcv/NC)*16 + (rcv%NC));
                chk("wrap_data", 32'(out_data), 32'(exp_s));
                chk("wrap_ch",   32'(out_ch),   32'(rcv%NC));
                rcv++;
            end
            if (in_valid) pushed++;
            tick();
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        chk("wrap_rcv",   32'(rcv),        32'(12*NC));
        chk("wrap_count", 32'(fifo_count), 32'd0);
        chk("wrap_ovf",   32'(overflow),   32'd0);

        // ---------------- 5. simultaneous events ----------------
        push(16'h400); push(16'h410); push(16'h420);
        chk("sim_count3", 32'(fifo_count), 32'd3);
        out_ready = 1'b1;
        tick(); tick(); tick();
        chk("sim_last", 32'(out_last), 32'd1);
        in_valid = 1'b1; in_data = mkframe(16'h430);
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        chk("sim_count_keep", 32'(fifo_count), 32'd3);
        chk("sim_head",       32'(out_data),   32'h410);
        chk("sim_ch0",        32'(out_ch),     32'd0);
        push(16'h440); push(16'h450); push(16'h460); push(16'h470); push(16'h480);
        chk("sim_count8", 32'(fifo_count), 32'd8);
        out_ready = 1'b1;
        tick(); tick(); tick();
        in_valid = 1'b1; in_data = mkframe(16'h490);
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        chk("fullpop_ovf",   32'(overflow),   32'd1);
        chk("fullpop_count", 32'(fifo_count), 32'd7);
        chk("fullpop_head",  32'(out_data),   32'h420);
        // Drop coincident with clear: set must win.
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        chk("clr_alone", 32'(overflow), 32'd0);
        push(16'h4A0);
        in_valid = 1'b1; clr_overflow = 1'b1;
        tick();
        in_valid = 1'b0; clr_overflow = 1'b0;
        chk("set_wins", 32'(overflow), 32'd1);

        // ---------------- 6. reset mid-frame ----------------
        reset = 1'b1; tick(); reset = 1'b0;
        push(16'h500);
        out_ready = 1'b1;
        tick(); tick();
        out_ready = 1'b0;
        chk("mid_ch2", 32'(out_ch), 32'd2);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("mid_valid", 32'(out_valid),  32'd0);
        chk("mid_ch",    32'(out_ch),     32'd0);
        chk("mid_count", 32'(fifo_count), 32'd0);
        chk("mid_ovf",   32'(overflow),   32'd0);
        push(16'h600);
        chk("after_ch",   32'(out_ch),   32'd0);
        chk("after_data", 32'(out_data), 32'h600);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_ch_in_buff
`default_nettype wire
